a_optimisation_pack: RTL and testbench
======================================

Name: a_optimisation_pack

Overview:
- Run-length encoder on the trace/capture side of the emulation control path.
- Watches a per-user-cycle stimulus-enable level and counts consecutive enabled user cycles.
- Emits each completed run as a 16-bit control word {run_len, 1'b1} with a valid/ready handshake toward the downstream FIFO/link.
- Its output words are the exact format the stimulus-enable decoder consumes: bit0 = run flag, bits[15:1] = run length in user cycles.

Parameters:
- CNT_W, 15, run-length counter width; the output word is CNT_W+1 bits. It must stay 15 to match the decoder.

Ports:
- clk_ref  input  1  reference clock; all logic runs on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_user_i  input  1  one-clk_ref-cycle pulse marking a user-clock tick; sampling happens only on pulses.
- run_verif_i  input  1  verification run active; low aborts and flushes.
- en_stimuli_i  input  1  stimulus-enable level, sampled on clk_user_i.
- ready_i  input  1  downstream accepts the word this cycle.
- val_cpt_o  output  CNT_W+1  encoded word {run_len[CNT_W-1:0], 1'b1}.
- data_valid_o  output  1  val_cpt_o holds a valid word.
- overflow_o  output  1  sticky flag: a completed run was dropped.

Behaviour:
- Reset (async, rst_n=0) values:
  - data_valid_o=0, val_cpt_o=0, overflow_o=0.
  - FSM returns to IDLE and the run counter clears to 0.
- Reset mid-run discards the partial run and any held word. No flush on reset.
- Sample event = clk_user_i && run_verif_i. No state changes in cycles without a sample event, except handshake/abort handling.
- Counting FSM, states IDLE and COUNT:
  - IDLE: on a sample with en_stimuli_i=1, set cnt<=1 and go to COUNT. On a sample with en_stimuli_i=0, stay in IDLE.
  - COUNT, sample with en_stimuli_i=1 and cnt<2^CNT_W-1: cnt<=cnt+1.
  - COUNT, sample with en_stimuli_i=1 and cnt==2^CNT_W-1 (saturation): complete the word with cnt, then set cnt<=1 and stay in COUNT. The current sample starts the next run.
  - COUNT, sample with en_stimuli_i=0: complete the word with cnt, then set cnt<=0 and go to IDLE.
  - COUNT with run_verif_i=0 (abort): complete the word with the current cnt (cnt>=1 is guaranteed), then go to IDLE. clk_user_i is ignored that cycle.
  - IDLE with run_verif_i=0: no action.
- Completion loads the output slot on the next edge: val_cpt_o<={cnt,1'b1}, data_valid_o<=1. Latency is 1 clk_ref cycle from the completing sample.
- Handshake:
  - A transfer occurs when data_valid_o && ready_i.
  - data_valid_o and val_cpt_o stay stable until the transfer.
  - After a transfer with no new completion in the same cycle, data_valid_o<=0 and val_cpt_o keeps its last value.
- Simultaneous transfer and completion: the new word loads, data_valid_o stays 1, no overflow.
- Completion while the slot is full and ready_i=0:
  - The new word is dropped and the held word is kept.
  - overflow_o<=1. It is sticky and clears only on reset.
- Counter arithmetic is unsigned CNT_W bits and never wraps; saturation splits the run instead.
- Bit0 of every emitted word is 1. A word is never emitted with run_len=0.

Optional Feature:
- Macro A_OPT_PACK_STATS_EN.
- When defined:
  - Adds output word_cnt_o[15:0], the count of transferred words.
  - word_cnt_o increments on each data_valid_o && ready_i, wraps 0xFFFF->0, and resets to 0.
  - Adds output drop_cnt_o[7:0], which increments on each dropped word and saturates at 0xFF.
- When undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Run of 5 enabled user ticks then 1 disabled tick, ready_i=1 -> exactly one word 0x000B (run_len=5), data_valid_o high for 1 cycle, 1 cycle after the disabled tick.
- 32768 consecutive enabled ticks, ready_i=1 -> word 0xFFFF (run_len=32767), then after a disable tick word 0x0003 (run_len=1); overflow_o=0.
- run_verif_i dropped after 3 enabled ticks -> word 0x0007 next cycle; FSM back to IDLE; ticks with run_verif_i=0 produce nothing.
- ready_i=0; run of 2 completes, then run of 4 completes -> val_cpt_o stays 0x0005, overflow_o=1; raising ready_i transfers 0x0005 only.
- Word held, ready_i=1 on the same cycle a run of 7 completes -> 0x0005 transferred, 0x000F loaded, data_valid_o continuous, overflow_o=0.
- rst_n pulsed low mid-run (cnt=9) with a word pending -> data_valid_o=0 immediately, no word emitted afterwards for that run; next run of 1 gives 0x0003.

Source files
------------

// File: rtl/a_optimisation_pack.sv
// Run-length encoder for the stimulus-enable trace: emits {run_len, 1'b1} words over valid/ready.
// Optional transfer/drop statistics ports are enabled by defining A_OPT_PACK_STATS_EN.
module a_optimisation_pack #(
   parameter int unsigned CNT_W = 15
) (
   input  logic             clk_ref,
   input  logic             rst_n,
   input  logic             clk_user_i,
   input  logic             run_verif_i,
   input  logic             en_stimuli_i,
   input  logic             ready_i,
   output logic [CNT_W:0]   val_cpt_o,
   output logic             data_valid_o,
`ifdef A_OPT_PACK_STATS_EN
   output logic [15:0]      word_cnt_o,
   output logic [7:0]       drop_cnt_o,
`endif
   output logic             overflow_o
);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             complete;
   logic             xfer;
   logic             load;
   logic             drop;

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Abort takes priority over the tick; a saturated run closes and the same tick opens the next.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      complete = 1'b0;
      case (state)
         IDLE: begin
            if (clk_user_i && run_verif_i && en_stimuli_i) begin
               cnt_nx   = CNT_W'(1);
               state_nx = COUNT;
            end
         end
         COUNT: begin
            if (!run_verif_i) begin
               complete = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (clk_user_i) begin
               if (en_stimuli_i) begin
                  if (cnt == '1) begin
                     complete = 1'b1;
                     cnt_nx   = CNT_W'(1);
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end else begin
                  complete = 1'b1;
                  cnt_nx   = '0;
                  state_nx = IDLE;
               end
            end
         end
      endcase
   end

   assign xfer = data_valid_o && ready_i;
   assign load = complete && (!data_valid_o || ready_i);
   assign drop = complete && data_valid_o && !ready_i;

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         val_cpt_o    <= '0;
         data_valid_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         if (load) begin
            val_cpt_o    <= {cnt, 1'b1};
            data_valid_o <= 1'b1;
         end else if (xfer) begin
            data_valid_o <= 1'b0;
         end
         if (drop) begin
            overflow_o <= 1'b1;
         end
      end
   end

`ifdef A_OPT_PACK_STATS_EN
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_o <= '0;
         drop_cnt_o <= '0;
      end else begin
         if (xfer) begin
            word_cnt_o <= word_cnt_o + 16'd1;
         end
         if (drop && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_a_optimisation_pack.sv
// Bench for a_optimisation_pack: directed run-length scenarios plus random traffic against a run-length model.
module tb_a_optimisation_pack;

   localparam int unsigned CNT_W   = 15;
   localparam int          MAX_RUN = 32767;

   logic          clk_ref = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_user_i = 1'b0;
   logic          run_verif_i = 1'b0;
   logic          en_stimuli_i = 1'b0;
   logic          ready_i = 1'b0;
   logic [CNT_W:0] val_cpt_o;
   logic          data_valid_o;
   logic          overflow_o;
`ifdef A_OPT_PACK_STATS_EN
   logic [15:0]   word_cnt_o;
   logic [7:0]    drop_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: length of the open run (0 = none), the output slot and sticky flag.
   int            m_run = 0;
   bit            m_valid = 1'b0;
   logic [15:0]   m_word = '0;
   bit            m_ovf = 1'b0;
   int            m_words = 0;
   int            m_drops = 0;

   a_optimisation_pack #(.CNT_W(CNT_W)) dut (
      .clk_ref      (clk_ref),
      .rst_n        (rst_n),
      .clk_user_i   (clk_user_i),
      .run_verif_i  (run_verif_i),
      .en_stimuli_i (en_stimuli_i),
      .ready_i      (ready_i),
      .val_cpt_o    (val_cpt_o),
      .data_valid_o (data_valid_o),
`ifdef A_OPT_PACK_STATS_EN
      .word_cnt_o   (word_cnt_o),
      .drop_cnt_o   (drop_cnt_o),
`endif
      .overflow_o   (overflow_o)
   );

   always #5 clk_ref = ~clk_ref;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("data_valid", 32'(data_valid_o), 32'(m_valid));
      check("val_cpt", 32'(val_cpt_o), 32'(m_word));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
`ifdef A_OPT_PACK_STATS_EN
      check("word_cnt", 32'(word_cnt_o), 32'(m_words % 65536));
      check("drop_cnt", 32'(drop_cnt_o), 32'((m_drops > 255) ? 255 : m_drops));
`endif
   endtask

   task automatic model_reset();
      m_run   = 0;
      m_valid = 1'b0;
      m_word  = '0;
      m_ovf   = 1'b0;
      m_words = 0;
      m_drops = 0;
   endtask

   // One clk_ref cycle: drive inputs, advance the model, check just after the edge.
   task automatic step(input bit cu, input bit rv, input bit en, input bit rdy);
      int  done_len;
      bit  done;
      clk_user_i   = cu;
      run_verif_i  = rv;
      en_stimuli_i = en;
      ready_i      = rdy;
      done = 1'b0;
      done_len = 0;
      if (m_run > 0 && !rv) begin
         done = 1'b1; done_len = m_run; m_run = 0;
      end else if (rv && cu) begin
         if (en) begin
            if (m_run == MAX_RUN) begin
               done = 1'b1; done_len = m_run; m_run = 1;
            end else begin
               m_run++;
            end
         end else if (m_run > 0) begin
            done = 1'b1; done_len = m_run; m_run = 0;
         end
      end
      if (m_valid && rdy) m_words++;
      if (done) begin
         if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_word  = 16'(done_len * 2 + 1);
         end else begin
            m_ovf = 1'b1;
            m_drops++;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk_ref);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_valid", 32'(data_valid_o), 32'd0);
      check("rst_val", 32'(val_cpt_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      @(negedge clk_ref);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Run of 5 then a disabled tick.
      for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
      check("t1_none_yet", 32'(data_valid_o), 32'd0);
      step(1, 1, 0, 1);
      check("t1_word", 32'(val_cpt_o), 32'h000B);
      check("t1_valid", 32'(data_valid_o), 32'd1);
      step(0, 1, 0, 1);
      check("t1_valid_drop", 32'(data_valid_o), 32'd0);

      // Saturation splits the run.
      for (int i = 0; i < 32768; i++) step(1, 1, 1, 1);
      check("t2_sat_word", 32'(val_cpt_o), 32'hFFFF);
      check("t2_sat_valid", 32'(data_valid_o), 32'd1);
      step(1, 1, 0, 1);
      check("t2_tail_word", 32'(val_cpt_o), 32'h0003);
      check("t2_ovf", 32'(overflow_o), 32'd0);
      step(0, 1, 0, 1);

      // Abort after 3 ticks; ticks while stopped produce nothing.
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
      step(1, 0, 1, 1);
      check("t3_abort_word", 32'(val_cpt_o), 32'h0007);
      check("t3_abort_valid", 32'(data_valid_o), 32'd1);
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      check("t3_idle_quiet", 32'(data_valid_o), 32'd0);
      step(1, 1, 0, 1);

      // Held word transferred in the same cycle a run of 7 completes.
      step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 1, 1, 0);
      check("t5_held", 32'(val_cpt_o), 32'h0005);
      step(1, 1, 0, 1);
      check("t5_new_word", 32'(val_cpt_o), 32'h000F);
      check("t5_valid_cont", 32'(data_valid_o), 32'd1);
      check("t5_ovf", 32'(overflow_o), 32'd0);
      step(0, 1, 0, 1);

      // Full slot: second word is dropped and overflow sticks.
      step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
      step(1, 1, 0, 0);
      check("t4_kept", 32'(val_cpt_o), 32'h0005);
      check("t4_ovf", 32'(overflow_o), 32'd1);
      step(0, 1, 0, 1);
      check("t4_after_xfer", 32'(data_valid_o), 32'd0);
      step(0, 1, 0, 1);
      check("t4_ovf_sticky", 32'(overflow_o), 32'd1);

      // Reset mid-run with a word pending.
      do_reset();
      step(1, 1, 1, 0); step(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) step(1, 1, 1, 0);
      check("t6_pending", 32'(data_valid_o), 32'd1);
      do_reset();
      step(1, 1, 0, 1);
      check("t6_no_word", 32'(data_valid_o), 32'd0);
      step(1, 1, 1, 1); step(1, 1, 0, 1);
      check("t6_run1", 32'(val_cpt_o), 32'h0003);
      step(0, 1, 0, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0),
              ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
